// File: rtl/hls_run_sequencer_if.sv
// Bundle of command, stream, accelerator-control and lane-0 slave RAM signals
// for the run sequencer; slave = sequencer side, master = host/environment side.
interface hls_run_sequencer_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned CNT_W  = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_addr;
  logic [LEN_W-1:0]  cmd_load_words;
  logic [LEN_W-1:0]  cmd_read_words;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              acc_reset;
  logic              acc_start;
  logic              acc_done;
  logic              s_oe;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [6:0]        s_size;
  logic [DATA_W-1:0] s_rdata;
  logic              s_rdy;
  logic              busy;
  logic              status_valid;
  logic [1:0]        status_code;
  logic [CNT_W-1:0]  cycles;

  modport slave (
    input  cmd_valid, cmd_base_addr, cmd_load_words, cmd_read_words,
    input  ld_valid, ld_data, rd_ready, acc_done, s_rdata, s_rdy,
    output cmd_ready, ld_ready, rd_valid, rd_data, acc_reset, acc_start,
    output s_oe, s_we, s_addr, s_wdata, s_size, busy, status_valid,
    output status_code, cycles
  );

  modport master (
    output cmd_valid, cmd_base_addr, cmd_load_words, cmd_read_words,
    output ld_valid, ld_data, rd_ready, acc_done, s_rdata, s_rdy,
    input  cmd_ready, ld_ready, rd_valid, rd_data, acc_reset, acc_start,
    input  s_oe, s_we, s_addr, s_wdata, s_size, busy, status_valid,
    input  status_code, cycles
  );
endinterface

// File: rtl/hls_run_sequencer.sv
// Run controller for one HLS accelerator: reset, preload over lane 0, start,
// time to done (with watchdog), read back over lane 0, report status.
module hls_run_sequencer #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 200000000
) (
  input logic                clock,
  input logic                reset,
  hls_run_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ARST, LOAD, START, RUN, ABORT, READ, REPORT
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  nload_q, nload_d;
  logic [LEN_W-1:0]  nread_q, nread_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [1:0]        code_q, code_d;
  logic              s_we_q, s_we_d;
  logic              s_oe_q, s_oe_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      nload_q    <= '0;
      nread_q    <= '0;
      wcnt_q     <= '0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      cycles_q   <= '0;
      code_q     <= '0;
      s_we_q     <= 1'b0;
      s_oe_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      nload_q    <= nload_d;
      nread_q    <= nread_d;
      wcnt_q     <= wcnt_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      cycles_q   <= cycles_d;
      code_q     <= code_d;
      s_we_q     <= s_we_d;
      s_oe_q     <= s_oe_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    nload_d    = nload_q;
    nread_d    = nread_q;
    wcnt_d     = wcnt_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    cycles_d   = cycles_q;
    code_d     = code_q;
    s_we_d     = s_we_q;
    s_oe_d     = s_oe_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          base_d  = bus.cmd_base_addr;
          addr_d  = bus.cmd_base_addr;
          nload_d = bus.cmd_load_words;
          nread_d = bus.cmd_read_words;
          wcnt_d  = '0;
          phase_d = 1'b0;
          state_d = ARST;
        end
      end
      ARST: begin
        phase_d = 1'b1;
        if (phase_q) begin
          phase_d = 1'b0;
          state_d = (nload_q == '0) ? START : LOAD;
        end
      end
      LOAD: begin
        // A write stays on the bus until DataRdy; the next word is only accepted after.
        if (!s_we_q) begin
          if (bus.ld_valid) begin
            s_we_d    = 1'b1;
            s_addr_d  = addr_q;
            s_wdata_d = bus.ld_data;
          end
        end else if (bus.s_rdy) begin
          s_we_d = 1'b0;
          addr_d = addr_q + STEP;
          wcnt_d = wcnt_q + LEN_W'(1);
          if (wcnt_q + LEN_W'(1) == nload_q) begin
            state_d = START;
          end
        end
      end
      START: begin
        cnt_d   = CNT_W'(1);
        state_d = RUN;
      end
      RUN: begin
        if (bus.acc_done) begin
          cycles_d = cnt_q;
          code_d   = 2'b00;
          addr_d   = base_q;
          wcnt_d   = '0;
          state_d  = (nread_q == '0) ? REPORT : READ;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          cycles_d = CNT_W'(TIMEOUT);
          code_d   = 2'b01;
          phase_d  = 1'b0;
          state_d  = ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ABORT: begin
        phase_d = 1'b1;
        if (phase_q) begin
          phase_d = 1'b0;
          state_d = REPORT;
        end
      end
      READ: begin
        // Holding a word for the consumer blocks the next slave read.
        if (rd_valid_q) begin
          if (bus.rd_ready) begin
            rd_valid_d = 1'b0;
            wcnt_d     = wcnt_q + LEN_W'(1);
            if (wcnt_q + LEN_W'(1) == nread_q) begin
              state_d = REPORT;
            end
          end
        end else if (!s_oe_q) begin
          s_oe_d   = 1'b1;
          s_addr_d = addr_q;
        end else if (bus.s_rdy) begin
          s_oe_d     = 1'b0;
          rd_data_d  = bus.s_rdata;
          rd_valid_d = 1'b1;
          addr_d     = addr_q + STEP;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.acc_reset    = !((state_q == ARST) || (state_q == ABORT));
  assign bus.acc_start    = (state_q == START);
  assign bus.ld_ready     = (state_q == LOAD) && !s_we_q;
  assign bus.status_valid = (state_q == REPORT);
  assign bus.status_code  = code_q;
  assign bus.cycles       = cycles_q;
  assign bus.s_we         = s_we_q;
  assign bus.s_oe         = s_oe_q;
  assign bus.s_addr       = s_addr_q;
  assign bus.s_wdata      = s_wdata_q;
  assign bus.s_size       = 7'(DATA_W);
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Scoreboard bench for hls_run_sequencer: slave RAM, accelerator and stream
// models drive the DUT; a negedge monitor pops and compares expectations.
module tb_hls_run_sequencer;
  localparam int unsigned AW  = 9;
  localparam int unsigned DW  = 64;
  localparam int unsigned LW  = 8;
  localparam int unsigned CW  = 32;
  localparam int unsigned TMO = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hls_run_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .CNT_W(CW)) bus ();

  hls_run_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .CNT_W(CW), .TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  typedef struct {
    logic [1:0]    code;
    logic [CW-1:0] cyc;
    int            arst;
  } st_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  st_t           exp_st[$];
  logic [DW-1:0] ld_q[$];
  logic [DW-1:0] ref_mem[512];
  logic [DW-1:0] mem[512];

  int errors = 0;
  int checks = 0;
  int done_delay = 0;
  int status_seen = 0;
  int mem_lat = 0;
  int mem_dly = 1;
  int acc_k = 0;
  bit acc_armed = 1'b0;
  bit ld_take = 1'b0;
  int rd_stall = 0;
  bit prev_stall = 1'b0;
  bit prev_status = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int starts = 0;
  int arsts = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave RAM lane 0: random DataRdy latency per access, single outstanding access
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        bus.s_rdy = 1'b0;
        mem_lat   = 0;
      end else if (bus.s_rdy) begin
        bus.s_rdy = 1'b0;
      end else if (bus.s_we || bus.s_oe) begin
        if (mem_lat == 0) mem_dly = bus.s_we ? $urandom_range(1, 2) : $urandom_range(1, 3);
        mem_lat++;
        if (mem_lat >= mem_dly) begin
          if (bus.s_we) mem[bus.s_addr] = bus.s_wdata;
          else bus.s_rdata = mem[bus.s_addr];
          bus.s_rdy = 1'b1;
          mem_lat   = 0;
        end
      end
    end
  end

  // Accelerator: done pulses done_delay cycles after the start cycle (0 = never)
  initial begin
    forever begin
      @(posedge clock);
      #1;
      bus.acc_done = 1'b0;
      if (!reset || !bus.acc_reset) begin
        acc_armed = 1'b0;
      end else if (bus.acc_start) begin
        acc_armed = 1'b1;
        acc_k     = 0;
      end else if (acc_armed) begin
        acc_k++;
        if (done_delay > 0 && acc_k == done_delay) begin
          bus.acc_done = 1'b1;
          acc_armed    = 1'b0;
        end
      end
    end
  end

  // Preload stream source with random gaps; a presented word is held until taken
  initial begin
    forever begin
      @(negedge clock);
      ld_take = bus.ld_valid && bus.ld_ready && reset;
      @(posedge clock);
      #1;
      if (ld_take) void'(ld_q.pop_front());
      if (ld_take || !bus.ld_valid) begin
        if (ld_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          bus.ld_valid = 1'b1;
          bus.ld_data  = ld_q[0];
        end else begin
          bus.ld_valid = 1'b0;
          bus.ld_data  = '0;
        end
      end
    end
  end

  // Readback sink: random ready with occasional 4-cycle stalls
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rd_stall > 0) begin
        bus.rd_ready = 1'b0;
        rd_stall--;
      end else if ($urandom_range(0, 5) == 0) begin
        bus.rd_ready = 1'b0;
        rd_stall     = 3;
      end else begin
        bus.rd_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor
  always @(negedge clock) begin
    if (reset) begin
      if (bus.s_we || bus.s_oe) chk("we_oe_exclusive", bus.s_we && bus.s_oe, 0);
      if (prev_stall) begin
        chk("rd_hold_valid", bus.rd_valid, 1);
        chk("rd_hold_data", bus.rd_data, prev_data);
      end
      prev_stall = bus.rd_valid && !bus.rd_ready;
      prev_data  = bus.rd_data;
      if (prev_status) chk("status_pulse_len", bus.status_valid, 0);
      prev_status = bus.status_valid;
      if (bus.acc_start) starts++;
      if (!bus.acc_reset) arsts++;
      if (bus.s_we && bus.s_rdy) begin
        if (exp_wr.size() == 0) chk("unexpected_write", exp_wr.size(), 1);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", bus.s_addr, w.a);
          chk("wr_data", bus.s_wdata, w.d);
          chk("s_size", bus.s_size, DW);
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_rd.size() == 0) chk("unexpected_read", exp_rd.size(), 1);
        else chk("rd_data", bus.rd_data, exp_rd.pop_front());
      end
      if (bus.status_valid) begin
        if (exp_st.size() == 0) chk("unexpected_status", exp_st.size(), 1);
        else begin
          st_t s;
          s = exp_st.pop_front();
          chk("status_code", bus.status_code, s.code);
          chk("cycles", bus.cycles, s.cyc);
          chk("start_pulses", starts, 1);
          chk("acc_reset_low_cycles", arsts, s.arst);
          chk("writes_outstanding", exp_wr.size(), 0);
          chk("reads_outstanding", exp_rd.size(), 0);
          chk("busy_in_report", bus.busy, 1);
        end
        starts = 0;
        arsts  = 0;
        status_seen++;
      end
    end
  end

  task automatic run_cmd(input int base, input int nl, input int nr, input int d);
    int n;
    int t;
    int hold;
    bit tmo;
    logic [DW-1:0] v;
    wr_t w;
    st_t s;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    for (int i = 0; i < nl; i++) begin
      v   = {$urandom, $urandom};
      w.a = AW'((base + 8 * i) % 512);
      w.d = v;
      exp_wr.push_back(w);
      ref_mem[(base + 8 * i) % 512] = v;
      ld_q.push_back(v);
    end
    tmo = (d > int'(TMO));
    if (!tmo) begin
      for (int i = 0; i < nr; i++) exp_rd.push_back(ref_mem[(base + 8 * i) % 512]);
    end
    s.code = tmo ? 2'b01 : 2'b00;
    s.cyc  = tmo ? CW'(TMO) : CW'(d);
    s.arst = tmo ? 4 : 2;
    exp_st.push_back(s);
    done_delay = tmo ? 0 : d;
    t = status_seen;
    @(posedge clock);
    #1;
    bus.cmd_base_addr  = AW'(base);
    bus.cmd_load_words = LW'(nl);
    bus.cmd_read_words = LW'(nr);
    bus.cmd_valid      = 1'b1;
    hold = $urandom_range(1, 3);
    repeat (hold) @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    chk("cmd_ready_busy", bus.cmd_ready, 0);
    n = 0;
    while (status_seen == t && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("cmd_complete", status_seen, t + 1);
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 512; i++) begin
      v          = {$urandom, $urandom};
      mem[i]     = v;
      ref_mem[i] = v;
    end
    bus.cmd_valid      = 1'b0;
    bus.cmd_base_addr  = '0;
    bus.cmd_load_words = '0;
    bus.cmd_read_words = '0;
    bus.ld_valid       = 1'b0;
    bus.ld_data        = '0;
    bus.rd_ready       = 1'b0;
    bus.acc_done       = 1'b0;
    bus.s_rdata        = '0;
    bus.s_rdy          = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_acc_reset", bus.acc_reset, 1);
    chk("rst_acc_start", bus.acc_start, 0);
    chk("rst_s_oe", bus.s_oe, 0);
    chk("rst_s_we", bus.s_we, 0);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_s_wdata", bus.s_wdata, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_status_valid", bus.status_valid, 0);
    chk("rst_status_code", bus.status_code, 0);
    chk("rst_cycles", bus.cycles, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    run_cmd(32'h10, 3, 2, 10);
    run_cmd(32'h40, 0, 0, 5);
    run_cmd(32'h80, 2, 3, TMO + 5);
    run_cmd(32'h1F8, 2, 2, 7);
    run_cmd(32'h20, 1, 1, TMO);
    run_cmd(32'h30, 4, 4, 1);
    for (int c = 0; c < 25; c++) begin
      run_cmd($urandom_range(0, 511), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(1, TMO + 4));
    end

    repeat (10) @(negedge clock);
    chk("final_wr_queue", exp_wr.size(), 0);
    chk("final_rd_queue", exp_rd.size(), 0);
    chk("final_st_queue", exp_st.size(), 0);
    chk("final_ld_queue", ld_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
